// File: rtl/hardroc_emu_pkg.sv
// Shared types and frame layout for the HARDROC chip emulator.
package hardroc_emu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACQ,
        FULL,
        READOUT,
        END
    } state_t;

    localparam int unsigned FRAME_BITS  = 32;
    localparam int unsigned BCID_W      = 16;
    localparam int unsigned CHIP_ID_LSB = 24;
    localparam int unsigned INDEX_LSB   = 16;
    localparam int unsigned BCID_LSB    = 0;

    typedef logic [FRAME_BITS-1:0] frame_t;
    typedef logic [BCID_W-1:0]     bcid_t;

    function automatic frame_t make_frame(logic [7:0] chip_id, logic [7:0] index, bcid_t bcid);
        frame_t f;
        f = '0;
        f[CHIP_ID_LSB +: 8]     = chip_id;
        f[INDEX_LSB +: 8]       = index;
        f[BCID_LSB +: BCID_W]   = bcid;
        return f;
    endfunction

endpackage

// File: rtl/hardroc_chip_emulator_if.sv
// DAQ <-> chip handshake bundle; master is the DAQ sequencer, slave is the chip.
interface hardroc_chip_emulator_if;

    logic       RESET_B;
    logic       PWR_ON_D;
    logic       START_ACQ;
    logic       StartReadout;
    logic       TrigExt;
    logic       CHIPSATB;
    logic       TransmitOn;
    logic       DOUT;
    logic       EndReadout;
    logic [7:0] FrameCount;

    modport master (
        output RESET_B, PWR_ON_D, START_ACQ, StartReadout, TrigExt,
        input  CHIPSATB, TransmitOn, DOUT, EndReadout, FrameCount
    );

    modport slave (
        input  RESET_B, PWR_ON_D, START_ACQ, StartReadout, TrigExt,
        output CHIPSATB, TransmitOn, DOUT, EndReadout, FrameCount
    );

endinterface

// File: rtl/hardroc_frame_mem.sv
// BCID frame store: one synchronous write port, one asynchronous read port.
module hardroc_frame_mem
    import hardroc_emu_pkg::*;
#(
    parameter int unsigned DEPTH = 127
) (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] waddr,
    input  bcid_t      wdata,
    input  logic [7:0] raddr,
    output bcid_t      rdata
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    bcid_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem[raddr[AW-1:0]];

endmodule

// File: rtl/hardroc_chip_emulator.sv
// Chip-side responder: records trigger BCIDs during acquisition and shifts
// the stored frames out serially, newest first, on a readout request.
module hardroc_chip_emulator
    import hardroc_emu_pkg::*;
#(
    parameter int unsigned MEM_DEPTH   = 127,
    parameter int unsigned TRIG_PERIOD = 16,
    parameter logic [7:0]  CHIP_ID     = 8'h01
) (
    input  logic                   Clk,
    input  logic                   reset_n,
    hardroc_chip_emulator_if.slave bus
);

    localparam logic [7:0]  DEPTH_CNT = 8'(MEM_DEPTH);
    localparam logic [31:0] TRIG_LAST = 32'(TRIG_PERIOD - 1);
    localparam bit          TRIG_EN   = (TRIG_PERIOD != 0);

    state_t      state;
    state_t      state_next;
    logic [7:0]  frame_count;
    logic [7:0]  count_inc;
    logic [7:0]  count_after;
    bcid_t       bcid;
    bcid_t       rd_bcid;
    logic [31:0] trig_cnt;
    logic [4:0]  bit_cnt;
    logic [7:0]  frame_idx;
    frame_t      frame_word;
    logic        chip_rst;
    logic        int_hit;
    logic        trig;
    logic        last_bit;

    logic        chipsatb, chipsatb_d;
    logic        transmit_on, transmit_on_d;
    logic        dout, dout_d;
    logic        end_readout, end_readout_d;

    assign chip_rst    = !reset_n || !bus.RESET_B || !bus.PWR_ON_D;
    assign int_hit     = TRIG_EN && (trig_cnt == TRIG_LAST);
    assign trig        = (state == ACQ) && (bus.TrigExt || int_hit);
    assign count_inc   = frame_count + 8'd1;
    assign count_after = trig ? count_inc : frame_count;
    assign last_bit    = (bit_cnt == 5'd31) && (frame_idx == 8'd0);
    assign frame_word  = make_frame(CHIP_ID, frame_idx, rd_bcid);

    hardroc_frame_mem #(
        .DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk   (Clk),
        .we    (trig),
        .waddr (frame_count),
        .wdata (bcid),
        .raddr (frame_idx),
        .rdata (rd_bcid)
    );

    always_ff @(posedge Clk) begin
        if (chip_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (bus.START_ACQ) begin
                    state_next = ACQ;
                end else if (bus.StartReadout) begin
                    state_next = (frame_count != 8'd0) ? READOUT : END;
                end
            end
            ACQ: begin
                // A readout request wins over a coincident START_ACQ drop so it is never lost.
                if (trig && (count_inc == DEPTH_CNT)) begin
                    state_next = FULL;
                end else if (bus.StartReadout) begin
                    state_next = (count_after != 8'd0) ? READOUT : END;
                end else if (!bus.START_ACQ) begin
                    state_next = IDLE;
                end
            end
            FULL: begin
                if (bus.StartReadout) begin
                    state_next = READOUT;
                end
            end
            READOUT: begin
                if (last_bit) begin
                    state_next = END;
                end
            end
            END:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        transmit_on_d = (state != READOUT);
        dout_d        = (state == READOUT) ? frame_word[5'd31 - bit_cnt] : 1'b0;
        end_readout_d = (state == END);
        chipsatb_d    = chipsatb;
        if (state == END) begin
            chipsatb_d = 1'b1;
        end else if ((state == ACQ) && (state_next == FULL)) begin
            chipsatb_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (chip_rst) begin
            chipsatb    <= 1'b1;
            transmit_on <= 1'b1;
            dout        <= 1'b0;
            end_readout <= 1'b0;
        end else begin
            chipsatb    <= chipsatb_d;
            transmit_on <= transmit_on_d;
            dout        <= dout_d;
            end_readout <= end_readout_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (chip_rst) begin
            frame_count <= '0;
            bcid        <= '0;
            trig_cnt    <= '0;
            bit_cnt     <= '0;
            frame_idx   <= '0;
        end else begin
            if (state == ACQ) begin
                bcid     <= bcid + bcid_t'(1);
                trig_cnt <= int_hit ? '0 : trig_cnt + 32'd1;
                if (trig) begin
                    frame_count <= count_inc;
                end
            end else begin
                bcid     <= '0;
                trig_cnt <= '0;
            end

            if ((state != READOUT) && (state_next == READOUT)) begin
                frame_idx <= count_after - 8'd1;
                bit_cnt   <= '0;
            end else if (state == READOUT) begin
                bit_cnt <= bit_cnt + 5'd1;
                if ((bit_cnt == 5'd31) && (frame_idx != 8'd0)) begin
                    frame_idx <= frame_idx - 8'd1;
                end
            end

            if (state == END) begin
                frame_count <= '0;
            end
        end
    end

    assign bus.CHIPSATB   = chipsatb;
    assign bus.TransmitOn = transmit_on;
    assign bus.DOUT       = dout;
    assign bus.EndReadout = end_readout;
    assign bus.FrameCount = frame_count;

endmodule

// File: tb/tb_hardroc_chip_emulator.sv
// Directed bench: dut_a uses the internal trigger, dut_b external triggers only.
module tb_hardroc_chip_emulator;

    logic Clk;
    logic reset_n;
    int   errors;
    int   checks;

    hardroc_chip_emulator_if if_a ();
    hardroc_chip_emulator_if if_b ();

    hardroc_chip_emulator #(
        .MEM_DEPTH   (4),
        .TRIG_PERIOD (8),
        .CHIP_ID     (8'h01)
    ) dut_a (
        .Clk     (Clk),
        .reset_n (reset_n),
        .bus     (if_a)
    );

    hardroc_chip_emulator #(
        .MEM_DEPTH   (4),
        .TRIG_PERIOD (0),
        .CHIP_ID     (8'h01)
    ) dut_b (
        .Clk     (Clk),
        .reset_n (reset_n),
        .bus     (if_b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        checks++;
        if ({if_a.CHIPSATB, if_a.TransmitOn, if_a.DOUT, if_a.EndReadout, if_a.FrameCount} !== 12'b1100_0000_0000) begin
            errors++;
            $display("FAIL reset_a: got %b expected 110000000000",
                     {if_a.CHIPSATB, if_a.TransmitOn, if_a.DOUT, if_a.EndReadout, if_a.FrameCount});
        end
        checks++;
        if ({if_b.CHIPSATB, if_b.TransmitOn, if_b.DOUT, if_b.EndReadout, if_b.FrameCount} !== 12'b1100_0000_0000) begin
            errors++;
            $display("FAIL reset_b: got %b expected 110000000000",
                     {if_b.CHIPSATB, if_b.TransmitOn, if_b.DOUT, if_b.EndReadout, if_b.FrameCount});
        end
    endtask

    task automatic test_internal_trigger();
        int unsigned exp_cnt;
        logic        exp_sat;
        if_a.START_ACQ = 1'b1;
        step();
        for (int k = 1; k <= 40; k++) begin
            step();
            exp_cnt = (k / 8 > 4) ? 4 : k / 8;
            exp_sat = (k >= 32) ? 1'b0 : 1'b1;
            checks++;
            if (if_a.FrameCount !== 8'(exp_cnt) || if_a.CHIPSATB !== exp_sat) begin
                errors++;
                $display("FAIL int_trig k=%0d: got count=%0d chipsatb=%b expected count=%0d chipsatb=%b",
                         k, if_a.FrameCount, if_a.CHIPSATB, exp_cnt, exp_sat);
            end
        end
    endtask

    task automatic test_full_readout();
        logic [31:0] exp_w [4];
        logic [31:0] word;
        int          low_cnt;
        logic        end_seen;
        logic        sat_rose;
        exp_w[0] = 32'h0103001F;
        exp_w[1] = 32'h01020017;
        exp_w[2] = 32'h0101000F;
        exp_w[3] = 32'h01000007;
        low_cnt  = 0;
        end_seen = 1'b0;
        sat_rose = 1'b0;
        if_a.START_ACQ    = 1'b0;
        if_a.StartReadout = 1'b1;
        step();
        if_a.StartReadout = 1'b0;
        checks++;
        if (if_a.TransmitOn !== 1'b1) begin
            errors++;
            $display("FAIL full_tx_latency: got TransmitOn=%b expected 1", if_a.TransmitOn);
        end
        for (int i = 0; i < 4; i++) begin
            word = '0;
            for (int b = 0; b < 32; b++) begin
                step();
                word = {word[30:0], if_a.DOUT};
                if (if_a.TransmitOn === 1'b0) low_cnt++;
                if (if_a.EndReadout !== 1'b0) end_seen = 1'b1;
                if (if_a.CHIPSATB !== 1'b0) sat_rose = 1'b1;
            end
            checks++;
            if (word !== exp_w[i]) begin
                errors++;
                $display("FAIL full_frame%0d: got %h expected %h", i, word, exp_w[i]);
            end
        end
        checks++;
        if (low_cnt != 128 || end_seen || sat_rose) begin
            errors++;
            $display("FAIL full_during: got tx_low=%0d end_seen=%b sat_rose=%b expected 128 0 0",
                     low_cnt, end_seen, sat_rose);
        end
        step();
        checks++;
        if ({if_a.EndReadout, if_a.TransmitOn, if_a.CHIPSATB, if_a.DOUT, if_a.FrameCount} !== 12'b1110_0000_0000) begin
            errors++;
            $display("FAIL full_end: got %b expected 111000000000",
                     {if_a.EndReadout, if_a.TransmitOn, if_a.CHIPSATB, if_a.DOUT, if_a.FrameCount});
        end
        step();
        checks++;
        if (if_a.EndReadout !== 1'b0) begin
            errors++;
            $display("FAIL full_end_pulse: got EndReadout=%b expected 0", if_a.EndReadout);
        end
    endtask

    task automatic test_ext_trigger();
        logic [31:0] exp_w [2];
        logic [31:0] word;
        exp_w[0] = 32'h01010009;
        exp_w[1] = 32'h01000005;
        if_b.START_ACQ = 1'b1;
        step();
        repeat (5) step();
        if_b.TrigExt = 1'b1;
        step();
        if_b.TrigExt = 1'b0;
        repeat (3) step();
        if_b.TrigExt = 1'b1;
        step();
        if_b.TrigExt = 1'b0;
        checks++;
        if (if_b.FrameCount !== 8'd2) begin
            errors++;
            $display("FAIL ext_count: got %0d expected 2", if_b.FrameCount);
        end
        if_b.START_ACQ = 1'b0;
        repeat (3) step();
        checks++;
        if (if_b.FrameCount !== 8'd2 || if_b.CHIPSATB !== 1'b1) begin
            errors++;
            $display("FAIL ext_idle_keep: got count=%0d chipsatb=%b expected 2 1", if_b.FrameCount, if_b.CHIPSATB);
        end
        if_b.StartReadout = 1'b1;
        step();
        if_b.StartReadout = 1'b0;
        for (int i = 0; i < 2; i++) begin
            word = '0;
            for (int b = 0; b < 32; b++) begin
                step();
                word = {word[30:0], if_b.DOUT};
            end
            checks++;
            if (word !== exp_w[i]) begin
                errors++;
                $display("FAIL ext_frame%0d: got %h expected %h", i, word, exp_w[i]);
            end
        end
        step();
        checks++;
        if (if_b.EndReadout !== 1'b1 || if_b.FrameCount !== 8'd0 || if_b.TransmitOn !== 1'b1) begin
            errors++;
            $display("FAIL ext_end: got end=%b count=%0d tx=%b expected 1 0 1",
                     if_b.EndReadout, if_b.FrameCount, if_b.TransmitOn);
        end
        step();
    endtask

    task automatic test_empty_readout();
        logic tx_low;
        tx_low = 1'b0;
        if_b.StartReadout = 1'b1;
        step();
        if_b.StartReadout = 1'b0;
        if (if_b.TransmitOn !== 1'b1) tx_low = 1'b1;
        checks++;
        if (if_b.EndReadout !== 1'b0) begin
            errors++;
            $display("FAIL empty_early: got EndReadout=%b expected 0", if_b.EndReadout);
        end
        step();
        if (if_b.TransmitOn !== 1'b1) tx_low = 1'b1;
        checks++;
        if (if_b.EndReadout !== 1'b1) begin
            errors++;
            $display("FAIL empty_end: got EndReadout=%b expected 1", if_b.EndReadout);
        end
        step();
        if (if_b.TransmitOn !== 1'b1) tx_low = 1'b1;
        checks++;
        if (if_b.EndReadout !== 1'b0 || tx_low) begin
            errors++;
            $display("FAIL empty_after: got EndReadout=%b tx_low=%b expected 0 0", if_b.EndReadout, tx_low);
        end
    endtask

    task automatic test_reset_mid_readout();
        logic end_seen;
        logic tx_low;
        end_seen = 1'b0;
        tx_low   = 1'b0;
        if_a.START_ACQ = 1'b1;
        step();
        repeat (33) step();
        checks++;
        if (if_a.CHIPSATB !== 1'b0 || if_a.FrameCount !== 8'd4) begin
            errors++;
            $display("FAIL rstmid_pre: got chipsatb=%b count=%0d expected 0 4", if_a.CHIPSATB, if_a.FrameCount);
        end
        if_a.START_ACQ    = 1'b0;
        if_a.StartReadout = 1'b1;
        step();
        if_a.StartReadout = 1'b0;
        repeat (10) step();
        checks++;
        if (if_a.TransmitOn !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_active: got TransmitOn=%b expected 0", if_a.TransmitOn);
        end
        if_a.RESET_B = 1'b0;
        step();
        if_a.RESET_B = 1'b1;
        checks++;
        if ({if_a.TransmitOn, if_a.DOUT, if_a.CHIPSATB, if_a.EndReadout, if_a.FrameCount} !== 12'b1010_0000_0000) begin
            errors++;
            $display("FAIL rstmid_state: got %b expected 101000000000",
                     {if_a.TransmitOn, if_a.DOUT, if_a.CHIPSATB, if_a.EndReadout, if_a.FrameCount});
        end
        repeat (140) begin
            step();
            if (if_a.EndReadout !== 1'b0) end_seen = 1'b1;
            if (if_a.TransmitOn !== 1'b1) tx_low = 1'b1;
        end
        checks++;
        if (end_seen || tx_low) begin
            errors++;
            $display("FAIL rstmid_quiet: got end_seen=%b tx_low=%b expected 0 0", end_seen, tx_low);
        end
    endtask

    task automatic test_pwr_on();
        if_b.START_ACQ = 1'b1;
        step();
        repeat (2) step();
        if_b.TrigExt = 1'b1;
        step();
        if_b.TrigExt = 1'b0;
        checks++;
        if (if_b.FrameCount !== 8'd1) begin
            errors++;
            $display("FAIL pwr_pre: got count=%0d expected 1", if_b.FrameCount);
        end
        if_b.PWR_ON_D = 1'b0;
        step();
        if_b.PWR_ON_D  = 1'b1;
        if_b.START_ACQ = 1'b0;
        checks++;
        if (if_b.FrameCount !== 8'd0) begin
            errors++;
            $display("FAIL pwr_clear: got count=%0d expected 0", if_b.FrameCount);
        end
        repeat (3) step();
    endtask

    task automatic test_coincident();
        logic [31:0] word;
        if_a.START_ACQ = 1'b1;
        step();
        repeat (7) step();
        if_a.TrigExt      = 1'b1;
        if_a.StartReadout = 1'b1;
        step();
        if_a.TrigExt      = 1'b0;
        if_a.StartReadout = 1'b0;
        if_a.START_ACQ    = 1'b0;
        checks++;
        if (if_a.FrameCount !== 8'd1) begin
            errors++;
            $display("FAIL coin_count: got %0d expected 1", if_a.FrameCount);
        end
        word = '0;
        for (int b = 0; b < 32; b++) begin
            step();
            word = {word[30:0], if_a.DOUT};
        end
        checks++;
        if (word !== 32'h01000007) begin
            errors++;
            $display("FAIL coin_frame: got %h expected 01000007", word);
        end
        step();
        checks++;
        if (if_a.EndReadout !== 1'b1 || if_a.FrameCount !== 8'd0) begin
            errors++;
            $display("FAIL coin_end: got end=%b count=%0d expected 1 0", if_a.EndReadout, if_a.FrameCount);
        end
        step();
    endtask

    initial begin
        errors            = 0;
        checks            = 0;
        reset_n           = 1'b0;
        if_a.RESET_B      = 1'b1;
        if_a.PWR_ON_D     = 1'b1;
        if_a.START_ACQ    = 1'b0;
        if_a.StartReadout = 1'b0;
        if_a.TrigExt      = 1'b0;
        if_b.RESET_B      = 1'b1;
        if_b.PWR_ON_D     = 1'b1;
        if_b.START_ACQ    = 1'b0;
        if_b.StartReadout = 1'b0;
        if_b.TrigExt      = 1'b0;

        test_reset();
        test_internal_trigger();
        test_full_readout();
        test_ext_trigger();
        test_empty_readout();
        test_reset_mid_readout();
        test_pwr_on();
        test_coincident();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
